mem_bus_arbiter: RTL and testbench

Two-requester memory bus arbiter and sequencer that shares one external Wishbone-style memory port between the instruction-fetch stage (IF) and the load/store path of the MEM stage. It registers each granted transaction onto the bus, waits for the slave acknowledge, returns read data to the owning requester, and raises per-requester stall requests toward the pipeline control unit while an access is pending. A timeout counter aborts accesses to unresponsive slaves.

---
 rtl/mem_bus_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter/sequencer. Shares one Wishbone-style
// master port between instruction fetch (IF) and the MEM load/store path,
// registers each granted access onto the bus, returns read data to the
// owner, and aborts accesses that exceed TIMEOUT bus cycles without an ack.
module mem_bus_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   // instruction fetch requester (read only)
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic [DW-1:0] if_data_o,
   output logic          if_ack_o,
   output logic          if_err_o,
   // load/store requester
   input  logic          mem_req_i,
   input  logic          mem_we_i,
   input  logic [3:0]    mem_sel_i,
   input  logic [AW-1:0] mem_addr_i,
   input  logic [DW-1:0] mem_wdata_i,
   output logic [DW-1:0] mem_rdata_o,
   output logic          mem_ack_o,
   output logic          mem_err_o,
   // external bus master port
   output logic          bus_cyc_o,
   output logic          bus_stb_o,
   output logic          bus_we_o,
   output logic [3:0]    bus_sel_o,
   output logic [AW-1:0] bus_addr_o,
   output logic [DW-1:0] bus_wdata_o,
   input  logic [DW-1:0] bus_rdata_i,
   input  logic          bus_ack_i,
   // stall requests toward pipeline control
   output logic          stallreq_if_o,
   output logic          stallreq_mem_o
);

   // A zero TIMEOUT disables the abort path; keep a 1-bit counter so the
   // declarations stay legal in that case.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_ACC  = 2'd1,
      MEM_ACC = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          last_grant_reg, last_grant_next;   // 1 = MEM was granted last
   logic          cyc_reg, cyc_next;
   logic          we_reg, we_next;
   logic [3:0]    sel_reg, sel_next;
   logic [AW-1:0] addr_reg, addr_next;
   logic [DW-1:0] wdata_reg, wdata_next;
   logic [DW-1:0] if_data_reg, if_data_next;
   logic [DW-1:0] mem_rdata_reg, mem_rdata_next;
   logic          if_ack_reg, if_ack_next;
   logic          if_err_reg, if_err_next;
   logic          mem_ack_reg, mem_ack_next;
   logic          mem_err_reg, mem_err_next;

   logic          if_elig, mem_elig;
   logic          grant_if, grant_mem;
   logic          timeout_hit;

   // A requester whose completion pulse is high this cycle is still holding
   // req for the access that just finished, so it must not be re-issued.
   assign if_elig   = if_req_i  & ~if_ack_reg  & ~if_err_reg;
   assign mem_elig  = mem_req_i & ~mem_ack_reg & ~mem_err_reg;
   // MEM has priority, except directly after a MEM grant when both compete.
   assign grant_mem = mem_elig & (~if_elig | ~last_grant_reg);
   assign grant_if  = if_elig & ~grant_mem;

   assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

   // Next-state and next-output logic for the access sequencer.
   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      last_grant_next = last_grant_reg;
      cyc_next        = cyc_reg;
      we_next         = we_reg;
      sel_next        = sel_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      if_data_next    = if_data_reg;
      mem_rdata_next  = mem_rdata_reg;
      if_ack_next     = 1'b0;
      if_err_next     = 1'b0;
      mem_ack_next    = 1'b0;
      mem_err_next    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (grant_mem) begin
               state_next      = MEM_ACC;
               cyc_next        = 1'b1;
               we_next         = mem_we_i;
               sel_next        = mem_sel_i;
               addr_next       = mem_addr_i;
               wdata_next      = mem_wdata_i;
               cnt_next        = '0;
               last_grant_next = 1'b1;
            end else if (grant_if) begin
               state_next      = IF_ACC;
               cyc_next        = 1'b1;
               we_next         = 1'b0;
               sel_next        = 4'b1111;
               addr_next       = if_addr_i;
               wdata_next      = '0;
               cnt_next        = '0;
               last_grant_next = 1'b0;
            end
         end
         IF_ACC, MEM_ACC: begin
            if (bus_ack_i) begin
               // Ack wins even in the cycle the timeout would fire.
               state_next = IDLE;
               cyc_next   = 1'b0;
               if (state_reg == IF_ACC) begin
                  if_data_next = bus_rdata_i;
                  if_ack_next  = 1'b1;
               end else begin
                  if (!we_reg) begin
                     mem_rdata_next = bus_rdata_i;
                  end
                  mem_ack_next = 1'b1;
               end
            end else if (timeout_hit) begin
               state_next = IDLE;
               cyc_next   = 1'b0;
               if (state_reg == IF_ACC) begin
                  if_err_next = 1'b1;
               end else begin
                  mem_err_next = 1'b1;
               end
            end else if (TIMEOUT != 0) begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            cyc_next   = 1'b0;
         end
      endcase
   end

   // State, bus qualifier, data and completion-pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         last_grant_reg <= 1'b0;
         cyc_reg        <= 1'b0;
         we_reg         <= 1'b0;
         sel_reg        <= '0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         if_data_reg    <= '0;
         mem_rdata_reg  <= '0;
         if_ack_reg     <= 1'b0;
         if_err_reg     <= 1'b0;
         mem_ack_reg    <= 1'b0;
         mem_err_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         last_grant_reg <= last_grant_next;
         cyc_reg        <= cyc_next;
         we_reg         <= we_next;
         sel_reg        <= sel_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
         if_data_reg    <= if_data_next;
         mem_rdata_reg  <= mem_rdata_next;
         if_ack_reg     <= if_ack_next;
         if_err_reg     <= if_err_next;
         mem_ack_reg    <= mem_ack_next;
         mem_err_reg    <= mem_err_next;
      end
   end

   assign bus_cyc_o   = cyc_reg;
   assign bus_stb_o   = cyc_reg;
   assign bus_we_o    = we_reg;
   assign bus_sel_o   = sel_reg;
   assign bus_addr_o  = addr_reg;
   assign bus_wdata_o = wdata_reg;
   assign if_data_o   = if_data_reg;
   assign if_ack_o    = if_ack_reg;
   assign if_err_o    = if_err_reg;
   assign mem_rdata_o = mem_rdata_reg;
   assign mem_ack_o   = mem_ack_reg;
   assign mem_err_o   = mem_err_reg;

   // Stall while a request is outstanding; forced low during reset so every
   // output reads zero while rst is held.
   assign stallreq_if_o  = if_req_i  & ~if_ack_reg  & ~if_err_reg  & ~rst;
   assign stallreq_mem_o = mem_req_i & ~mem_ack_reg & ~mem_err_reg & ~rst;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized
// single/dual requests checked against a transaction-level timing model.
module tb_mem_bus_arbiter;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int TO    = 16;
   localparam int NEVER = 1000;

   logic          clk, rst;
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic [DW-1:0] if_data_o;
   logic          if_ack_o, if_err_o;
   logic          mem_req_i, mem_we_i;
   logic [3:0]    mem_sel_i;
   logic [AW-1:0] mem_addr_i;
   logic [DW-1:0] mem_wdata_i, mem_rdata_o;
   logic          mem_ack_o, mem_err_o;
   logic          bus_cyc_o, bus_stb_o, bus_we_o;
   logic [3:0]    bus_sel_o;
   logic [AW-1:0] bus_addr_o;
   logic [DW-1:0] bus_wdata_o, bus_rdata_i;
   logic          bus_ack_i;
   logic          stallreq_if_o, stallreq_mem_o;

   int checks = 0;
   int fails  = 0;

   // slave behaviour per requester (IF addresses have bit31=0, MEM bit31=1)
   int            if_wait, mem_wait;
   logic [DW-1:0] if_rd, mem_rd;

   // reference model state
   bit            last_g;          // 1 = MEM granted last
   logic [DW-1:0] exp_if_data, exp_mem_rdata;

   mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
      .if_ack_o(if_ack_o), .if_err_o(if_err_o),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
      .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
      .mem_ack_o(mem_ack_o), .mem_err_o(mem_err_o),
      .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
      .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
      .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
      .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // slave: acks in bus cycle wait+1 of an access (wait >= NEVER: no ack)
   initial begin
      int            c;
      int            w;
      logic [DW-1:0] d;
      c = 0;
      bus_ack_i   = 1'b0;
      bus_rdata_i = '0;
      forever begin
         @(negedge clk);
         if (bus_cyc_o === 1'b1) begin
            c++;
            if (bus_addr_o[31]) begin
               w = mem_wait;
               d = mem_rd;
            end else begin
               w = if_wait;
               d = if_rd;
            end
            if (c == w + 1) begin
               bus_ack_i   = 1'b1;
               bus_rdata_i = d;
            end else begin
               bus_ack_i   = 1'b0;
               bus_rdata_i = $urandom();
            end
         end else begin
            c = 0;
            bus_ack_i = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int pick_wait();
      int p;
      p = $urandom_range(0, 9);
      if (p < 6)  return $urandom_range(0, 4);
      if (p == 6) return TO - 1;
      if (p == 7) return TO;
      if (p == 8) return NEVER;
      return TO - 2;
   endfunction

   // Issue IF and/or MEM requests at once (caller is 1 time unit after an edge,
   // DUT idle) and check each requester against the timing model.
   task automatic run_pair(input bit do_if, input bit do_mem, input bit drop_early,
                           input string name);
      int  len_if, len_mem, st_if, st_mem, end_if, end_mem, t_end;
      int  o_st_if, o_st_mem, o_end_if, o_end_mem, cyc_if, cyc_mem, pul_if, pul_mem;
      bit  ok_if, ok_mem, o_ok_if, o_ok_mem, mem_first;
      bit  stall_bad_if, stall_bad_mem, overlap, stb_bad, prev_cyc;
      logic [68:0] q_if, q_mem, e_if, e_mem;

      len_if  = (if_wait  < TO) ? if_wait  + 1 : TO;
      len_mem = (mem_wait < TO) ? mem_wait + 1 : TO;
      ok_if   = (if_wait  < TO);
      ok_mem  = (mem_wait < TO);
      mem_first = do_mem && (!do_if || !last_g);
      st_if = -1; st_mem = -1; end_if = -1; end_mem = -1;
      if (do_if && do_mem) begin
         if (mem_first) begin
            st_mem = 1; end_mem = st_mem + len_mem;
            st_if = end_mem + 1; end_if = st_if + len_if;
         end else begin
            st_if = 1; end_if = st_if + len_if;
            st_mem = end_if + 1; end_mem = st_mem + len_mem;
         end
      end else if (do_if) begin
         st_if = 1; end_if = st_if + len_if;
      end else begin
         st_mem = 1; end_mem = st_mem + len_mem;
      end
      t_end = (end_if > end_mem) ? end_if : end_mem;
      e_if  = {1'b0, 4'b1111, if_addr_i, 32'h0};
      e_mem = {mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i};

      o_st_if = -1; o_st_mem = -1; o_end_if = -1; o_end_mem = -1;
      cyc_if = 0; cyc_mem = 0; pul_if = 0; pul_mem = 0;
      o_ok_if = 0; o_ok_mem = 0; stall_bad_if = 0; stall_bad_mem = 0;
      overlap = 0; stb_bad = 0; prev_cyc = 0;
      q_if = '0; q_mem = '0;

      if_req_i  = do_if;
      mem_req_i = do_mem;
      for (int t = 1; t <= t_end + 2; t++) begin
         @(posedge clk); #1;
         if (bus_stb_o !== bus_cyc_o) stb_bad = 1;
         if (bus_cyc_o === 1'b1) begin
            if (bus_addr_o[31]) begin
               cyc_mem++;
               if (!prev_cyc) begin
                  o_st_mem = t;
                  q_mem = {bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o};
               end
            end else begin
               cyc_if++;
               if (!prev_cyc) begin
                  o_st_if = t;
                  q_if = {bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o};
               end
            end
         end
         prev_cyc = (bus_cyc_o === 1'b1);
         pul_if  += int'(if_ack_o) + int'(if_err_o);
         pul_mem += int'(mem_ack_o) + int'(mem_err_o);
         if ((if_ack_o || if_err_o) && (mem_ack_o || mem_err_o)) overlap = 1;
         if (if_ack_o || if_err_o) begin
            if (o_end_if < 0) begin
               o_end_if = t;
               o_ok_if  = if_ack_o;
            end
            if (stallreq_if_o !== 1'b0) stall_bad_if = 1;
            if_req_i = 1'b0;
         end else if (if_req_i && stallreq_if_o !== 1'b1) begin
            stall_bad_if = 1;
         end
         if (mem_ack_o || mem_err_o) begin
            if (o_end_mem < 0) begin
               o_end_mem = t;
               o_ok_mem  = mem_ack_o;
            end
            if (stallreq_mem_o !== 1'b0) stall_bad_mem = 1;
            mem_req_i = 1'b0;
         end else if (mem_req_i && stallreq_mem_o !== 1'b1) begin
            stall_bad_mem = 1;
         end
         if (drop_early && t == o_st_if)  if_req_i  = 1'b0;
         if (drop_early && t == o_st_mem) mem_req_i = 1'b0;
      end
      if_req_i  = 1'b0;
      mem_req_i = 1'b0;

      // reference model update
      if (do_if && ok_if) exp_if_data = if_rd;
      if (do_mem && ok_mem && !mem_we_i) exp_mem_rdata = mem_rd;
      if (do_if && do_mem) last_g = !mem_first;
      else last_g = do_mem;

      $display("txn %s: if=%0d mem=%0d drop=%0d if_wait=%0d mem_wait=%0d if_done@%0d mem_done@%0d",
               name, do_if, do_mem, drop_early, if_wait, mem_wait, o_end_if, o_end_mem);

      checks++;
      if (o_st_if !== st_if) begin
         fails++; $display("FAIL %s if_grant_cycle: got %0d want %0d", name, o_st_if, st_if);
      end
      checks++;
      if (o_st_mem !== st_mem) begin
         fails++; $display("FAIL %s mem_grant_cycle: got %0d want %0d", name, o_st_mem, st_mem);
      end
      checks++;
      if (o_end_if !== end_if) begin
         fails++; $display("FAIL %s if_done_cycle: got %0d want %0d", name, o_end_if, end_if);
      end
      checks++;
      if (o_end_mem !== end_mem) begin
         fails++; $display("FAIL %s mem_done_cycle: got %0d want %0d", name, o_end_mem, end_mem);
      end
      checks++;
      if (cyc_if !== (do_if ? len_if : 0)) begin
         fails++; $display("FAIL %s if_cyc_len: got %0d want %0d", name, cyc_if, do_if ? len_if : 0);
      end
      checks++;
      if (cyc_mem !== (do_mem ? len_mem : 0)) begin
         fails++; $display("FAIL %s mem_cyc_len: got %0d want %0d", name, cyc_mem, do_mem ? len_mem : 0);
      end
      checks++;
      if (pul_if !== int'(do_if) || pul_mem !== int'(do_mem)) begin
         fails++; $display("FAIL %s pulse_count: got if=%0d mem=%0d want if=%0d mem=%0d",
                           name, pul_if, pul_mem, do_if, do_mem);
      end
      if (do_if) begin
         checks++;
         if (o_ok_if !== ok_if) begin
            fails++; $display("FAIL %s if_ack_vs_err: got ack=%0d want ack=%0d", name, o_ok_if, ok_if);
         end
         checks++;
         if (q_if !== e_if) begin
            fails++; $display("FAIL %s if_bus_qual: got %h want %h", name, q_if, e_if);
         end
      end
      if (do_mem) begin
         checks++;
         if (o_ok_mem !== ok_mem) begin
            fails++; $display("FAIL %s mem_ack_vs_err: got ack=%0d want ack=%0d", name, o_ok_mem, ok_mem);
         end
         checks++;
         if (q_mem !== e_mem) begin
            fails++; $display("FAIL %s mem_bus_qual: got %h want %h", name, q_mem, e_mem);
         end
      end
      checks++;
      if ({stall_bad_if, stall_bad_mem, overlap, stb_bad} !== 4'b0000) begin
         fails++; $display("FAIL %s protocol: stall_if=%0d stall_mem=%0d overlap=%0d stb=%0d want all 0",
                           name, stall_bad_if, stall_bad_mem, overlap, stb_bad);
      end
      checks++;
      if (if_data_o !== exp_if_data) begin
         fails++; $display("FAIL %s if_data: got %h want %h", name, if_data_o, exp_if_data);
      end
      checks++;
      if (mem_rdata_o !== exp_mem_rdata) begin
         fails++; $display("FAIL %s mem_rdata: got %h want %h", name, mem_rdata_o, exp_mem_rdata);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      if_req_i = 1'b1; if_addr_i = 32'h0000_0040;
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF;
      mem_addr_i = 32'h8000_0040; mem_wdata_i = '0;
      if_wait = 0; mem_wait = 0; if_rd = '0; mem_rd = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, if_data_o,
           if_ack_o, if_err_o, mem_rdata_o, mem_ack_o, mem_err_o, stallreq_if_o,
           stallreq_mem_o} !== '0) begin
         fails++; $display("FAIL reset_outputs: cyc=%b addr=%h stall=%b%b want all zero",
                           bus_cyc_o, bus_addr_o, stallreq_if_o, stallreq_mem_o);
      end
      if_req_i = 1'b0; mem_req_i = 1'b0;
      rst = 1'b0;
      last_g = 1'b0; exp_if_data = '0; exp_mem_rdata = '0;
      @(posedge clk); #1;
      checks++;
      if (bus_cyc_o !== 1'b0) begin
         fails++; $display("FAIL reset_idle: bus_cyc got %b want 0", bus_cyc_o);
      end
   endtask

   task automatic test_alternation();
      int k;
      bit prev;
      bit exp_mem;
      if_addr_i = 32'h0000_0200; mem_addr_i = 32'h8000_0200;
      mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_wdata_i = '0;
      if_wait = 0; mem_wait = 0; if_rd = 32'h1111_0000; mem_rd = 32'h2222_0000;
      k = 0; prev = 0;
      if_req_i = 1'b1; mem_req_i = 1'b1;
      for (int t = 1; t <= 20; t++) begin
         @(posedge clk); #1;
         if (bus_cyc_o === 1'b1 && !prev) begin
            exp_mem = (k % 2 == 0);
            checks++;
            if (bus_addr_o[31] !== exp_mem) begin
               fails++; $display("FAIL alternation grant%0d: got mem=%b want mem=%b",
                                 k, bus_addr_o[31], exp_mem);
            end
            k++;
         end
         prev = (bus_cyc_o === 1'b1);
      end
      if_req_i = 1'b0; mem_req_i = 1'b0;
      $display("txn alternation: %0d grants in 20 cycles", k);
      checks++;
      if (k !== 10) begin
         fails++; $display("FAIL alternation_count: got %0d want 10", k);
      end
      last_g = 1'b0; exp_if_data = if_rd; exp_mem_rdata = mem_rd;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_if_read();
      if_addr_i = 32'h0000_0100; if_wait = 2; if_rd = 32'h3C01_0010;
      run_pair(1'b1, 1'b0, 1'b0, "if_read");
   endtask

   task automatic test_mem_write();
      mem_addr_i = 32'h8000_0004; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
      mem_wdata_i = 32'hDEAD_BEEF; mem_wait = 0; mem_rd = 32'h5A5A_A5A5;
      run_pair(1'b0, 1'b1, 1'b0, "mem_write");
   endtask

   task automatic test_timeout();
      if_addr_i = 32'h0000_0300; if_wait = 0; if_rd = 32'h0BAD_0001;
      run_pair(1'b1, 1'b0, 1'b0, "timeout_pre");
      mem_addr_i = 32'h8000_0300; mem_we_i = 1'b0; mem_sel_i = 4'hF;
      mem_wdata_i = '0; mem_wait = NEVER; mem_rd = 32'hFFFF_0000;
      if_addr_i = 32'h0000_0304; if_wait = 1; if_rd = 32'h0BAD_0002;
      run_pair(1'b1, 1'b1, 1'b0, "timeout");
   endtask

   task automatic test_ack_at_limit();
      mem_addr_i = 32'h8000_0400; mem_we_i = 1'b0; mem_sel_i = 4'hF;
      mem_wdata_i = '0; mem_wait = TO - 1; mem_rd = 32'h1234_5678;
      run_pair(1'b0, 1'b1, 1'b0, "ack_at_limit");
   endtask

   task automatic test_reset_mid_access();
      mem_addr_i = 32'h8000_0500; mem_we_i = 1'b0; mem_sel_i = 4'hF;
      mem_wdata_i = '0; mem_wait = 0; mem_rd = 32'hCAFE_F00D;
      run_pair(1'b0, 1'b1, 1'b0, "rst_pre");
      if_addr_i = 32'h0000_0500; if_wait = 5; if_rd = 32'h7777_0001;
      mem_rd = 32'h7777_0002;
      if_req_i = 1'b1; mem_req_i = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus_cyc_o !== 1'b1 || bus_addr_o !== if_addr_i) begin
         fails++; $display("FAIL rst_mid_if_granted: cyc=%b addr=%h want cyc=1 addr=%h",
                           bus_cyc_o, bus_addr_o, if_addr_i);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, if_data_o,
           if_ack_o, if_err_o, mem_rdata_o, mem_ack_o, mem_err_o, stallreq_if_o,
           stallreq_mem_o} !== '0) begin
         fails++; $display("FAIL rst_mid_outputs: cyc=%b addr=%h mem_rdata=%h stall=%b%b want all zero",
                           bus_cyc_o, bus_addr_o, mem_rdata_o, stallreq_if_o, stallreq_mem_o);
      end
      @(posedge clk); #1;
      checks++;
      if (bus_cyc_o !== 1'b0 || stallreq_if_o !== 1'b0) begin
         fails++; $display("FAIL rst_held: cyc=%b stall_if=%b want 0 0", bus_cyc_o, stallreq_if_o);
      end
      rst = 1'b0;
      last_g = 1'b0; exp_if_data = '0; exp_mem_rdata = '0;
      run_pair(1'b1, 1'b1, 1'b0, "rst_post");
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         int mode;
         mode = $urandom_range(1, 3);
         if_addr_i   = $urandom() & 32'h7FFF_FFFC;
         mem_addr_i  = $urandom() | 32'h8000_0000;
         mem_we_i    = 1'($urandom_range(0, 1));
         mem_sel_i   = 4'($urandom_range(1, 15));
         mem_wdata_i = $urandom();
         if_rd       = $urandom();
         mem_rd      = $urandom();
         if_wait     = pick_wait();
         mem_wait    = pick_wait();
         run_pair(mode[0], mode[1], 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
      end
   endtask

   initial begin
      test_reset();
      test_alternation();
      test_if_read();
      test_mem_write();
      test_timeout();
      test_ack_at_limit();
      test_reset_mid_access();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
